// File: rtl/md_stream_padder.sv
// Merkle-Damgard 512-bit block padder: byte stream in, padded blocks with first/final markers out.
// Optional MD_PAD_ERR_EN adds a sticky err output for over-range in_nbytes on the last beat.
module md_stream_padder #(
  parameter int IN_BYTES       = 8,
  parameter bit LEN_BIG_ENDIAN = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [8*IN_BYTES-1:0]     in_data,
  input  logic                      in_last,
  input  logic [$clog2(IN_BYTES):0] in_nbytes,
  output logic                      blk_valid,
  input  logic                      blk_ready,
  output logic [511:0]              blk_data,
  output logic                      blk_first,
  output logic                      blk_final
`ifdef MD_PAD_ERR_EN
  ,
  output logic                      err
`endif
);

  typedef enum logic [1:0] {S_FILL, S_EMIT, S_EMIT_LAST, S_PAD_BLK} state_t;

  localparam logic [6:0] FULL_N = 7'(IN_BYTES);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_buf [64];
  logic [7:0]  w_buf_nxt [64];
  logic [6:0]  r_ptr;
  logic [63:0] r_len;
  logic        r_pad_after;
  logic        r_pad_80;
  logic        r_first;

  logic        w_accept;
  logic        w_hs;
  logic        w_over;
  logic [6:0]  w_nb_ext;
  logic [6:0]  w_n;
  logic [6:0]  w_end;
  logic [63:0] w_len_nxt;

  function automatic logic [7:0] len_byte(input logic [63:0] len, input int i);
    if (LEN_BIG_ENDIAN) return len[8*(7-i) +: 8];
    else                return len[8*i +: 8];
  endfunction

  assign w_accept  = in_valid && in_ready;
  assign w_hs      = blk_valid && blk_ready;
  assign w_nb_ext  = 7'(in_nbytes);
  assign w_over    = in_last && (w_nb_ext > FULL_N);
  assign w_n       = (!in_last || w_over) ? FULL_N : w_nb_ext;
  // ptr is always a multiple of IN_BYTES, so ptr + n never exceeds 64
  assign w_end     = r_ptr + w_n;
  assign w_len_nxt = r_len + {54'd0, w_n, 3'd0};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_FILL;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FILL: begin
        if (w_accept) begin
          if (in_last)               w_state_nxt = (w_end <= 7'd55) ? S_EMIT_LAST : S_EMIT;
          else if (w_end == 7'd64)   w_state_nxt = S_EMIT;
        end
      end
      S_EMIT:      if (blk_ready) w_state_nxt = r_pad_after ? S_PAD_BLK : S_FILL;
      S_EMIT_LAST: if (blk_ready) w_state_nxt = S_FILL;
      S_PAD_BLK:   if (blk_ready) w_state_nxt = S_FILL;
      default:     w_state_nxt = S_FILL;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_FILL);
    blk_valid = (r_state != S_FILL);
    blk_final = (r_state == S_EMIT_LAST) || (r_state == S_PAD_BLK);
  end

  // Next buffer image: beat bytes, terminator and length land in the same update
  always_comb begin
    w_buf_nxt = r_buf;
    if (w_accept) begin
      for (int j = 0; j < 64; j++) begin
        if (7'(j) >= r_ptr && 7'(j) < w_end) w_buf_nxt[j] = in_data[8*(j%IN_BYTES) +: 8];
      end
      if (in_last && w_end < 7'd64) w_buf_nxt[w_end[5:0]] = 8'h80;
      if (in_last && w_end <= 7'd55) begin
        for (int i = 0; i < 8; i++) w_buf_nxt[56+i] = len_byte(w_len_nxt, i);
      end
    end else if (w_hs) begin
      for (int j = 0; j < 64; j++) w_buf_nxt[j] = 8'h00;
      if (r_state == S_EMIT && r_pad_after) begin
        w_buf_nxt[0] = r_pad_80 ? 8'h80 : 8'h00;
        for (int i = 0; i < 8; i++) w_buf_nxt[56+i] = len_byte(r_len, i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j < 64; j++) r_buf[j] <= 8'h00;
    end else begin
      r_buf <= w_buf_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr       <= 7'd0;
      r_len       <= 64'd0;
      r_pad_after <= 1'b0;
      r_pad_80    <= 1'b0;
      r_first     <= 1'b1;
    end else if (w_accept) begin
      r_ptr <= w_end;
      r_len <= w_len_nxt;
      if (in_last) begin
        r_pad_after <= (w_end > 7'd55);
        r_pad_80    <= (w_end == 7'd64);
      end
    end else if (w_hs) begin
      r_ptr   <= 7'd0;
      r_first <= blk_final;
      if (blk_final) begin
        r_len       <= 64'd0;
        r_pad_after <= 1'b0;
        r_pad_80    <= 1'b0;
      end
    end
  end

`ifdef MD_PAD_ERR_EN
  logic r_err;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                r_err <= 1'b0;
    else if (w_accept && w_over) r_err <= 1'b1;
  end
  assign err = r_err;
`endif

  assign blk_first = r_first;

  for (genvar g = 0; g < 64; g++) begin : g_map
    if (LEN_BIG_ENDIAN) begin : g_be
      assign blk_data[511-8*g -: 8] = r_buf[g];
    end else begin : g_le
      assign blk_data[8*g +: 8] = r_buf[g];
    end
  end

endmodule
